// File: rtl/pipomod_pkg.sv
// Shared constants for the pipomod parallel-in/parallel-out register.
package pipomod_pkg;

  // Default data width of the register.
  localparam int DEFAULT_WIDTH = 4;

  // Default value loaded into q while reset is asserted.
  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_RST_VAL = '0;

  // Widen or narrow the default reset value to an arbitrary register width.
  // Bits beyond the default width are zero.
  function automatic logic [63:0] default_rst_bits();
    logic [63:0] bits;
    bits = '0;
    bits[DEFAULT_WIDTH-1:0] = DEFAULT_RST_VAL;
    return bits;
  endfunction

endpackage : pipomod_pkg

// File: rtl/pipomod_dff_bit.sv
// Single-bit D flip-flop with asynchronous active-low reset to a per-bit value.
module dff_bit #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic q_q;

  // Capture d on every rising edge; reset forces the per-bit value at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RST_BIT;
    end else begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule : dff_bit

// File: rtl/pipomod.sv
// Parallel-in/parallel-out register: q takes a on every rising clk edge,
// one-edge latency, no load enable, asynchronous active-low reset to RST_VAL.
// This level is pure wiring: one dff_bit per data bit.
module pipomod
  import pipomod_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(default_rst_bits())
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] q
);

  // A zero-width register has no meaning; stop elaboration.
  generate
    if (WIDTH < 1) begin : g_width_check
      $error("pipomod: WIDTH must be >= 1");
    end
  endgenerate

  // Each bit is an independent flop so q[i] is always sourced from a[i].
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      dff_bit #(
        .RST_BIT (RST_VAL[gi])
      ) u_dff (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (a[gi]),
        .q_o   (q[gi])
      );
    end
  endgenerate

endmodule : pipomod

// File: tb/tb_pipomod.sv
// Directed self-checking bench for pipomod (default 4-bit instance plus a
// 1-bit instance with a non-zero reset value).
module tb_pipomod;

  logic       clk = 1'b1;
  logic       rst = 1'b1;
  logic [3:0] a   = 4'b1101;
  logic [3:0] q;
  logic       a1  = 1'b0;
  logic       q1;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [3:0] seq_v [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111};
  logic [3:0] prev_v;

  always #10 clk = ~clk;

  pipomod dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .q   (q)
  );

  pipomod #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) dut_w1 (
    .clk (clk),
    .rst (rst),
    .a   (a1),
    .q   (q1)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    $display("t=%0t %s observed=%b expected=%b", $time, tag, obs, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held from t=0 with a=1101.
    rst = 1'b0;
    a   = 4'b1101;
    a1  = 1'b0;
    #1;
    check("rst_t0", {4'b0, q}, 8'b0000);
    check("w1_rst_t0", {7'b0, q1}, 8'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_hold_edge", {4'b0, q}, 8'b0000);
      check("w1_rst_hold_edge", {7'b0, q1}, 8'b1);
    end

    // Release reset mid-cycle: no load until the next rising edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("release_no_load", {4'b0, q}, 8'b0000);
    check("w1_release_no_load", {7'b0, q1}, 8'b1);
    @(posedge clk); #1;
    check("first_load", {4'b0, q}, 8'b1101);
    check("w1_first_load", {7'b0, q1}, 8'b0);

    // Mid-cycle change of a is not seen until the next edge.
    @(negedge clk);
    a = 4'b1000;
    #1;
    check("mid_a_hold", {4'b0, q}, 8'b1101);
    @(posedge clk); #1;
    check("mid_a_load", {4'b0, q}, 8'b1000);

    // Asynchronous reset between edges clears immediately and ignores edges.
    #4;
    rst = 1'b0;
    #1;
    check("async_clear", {4'b0, q}, 8'b0000);
    check("w1_async_clear", {7'b0, q1}, 8'b1);
    @(posedge clk); #1;
    check("rst_edge_ignored", {4'b0, q}, 8'b0000);
    @(negedge clk);
    rst = 1'b1;
    a   = 4'b1000;
    #1;
    check("rerelease_no_load", {4'b0, q}, 8'b0000);
    @(posedge clk); #1;
    check("reload", {4'b0, q}, 8'b1000);

    // Walking-one and all-ones sequence, one edge of latency.
    prev_v = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = seq_v[i];
      #1;
      check("seq_pre_edge", {4'b0, q}, {4'b0, prev_v});
      @(posedge clk); #1;
      check("seq_load", {4'b0, q}, {4'b0, seq_v[i]});
      prev_v = seq_v[i];
    end

    // Unchanged a still loads on every edge.
    @(posedge clk); #1;
    check("no_enable_hold", {4'b0, q}, 8'b1111);

    // Glitch on a between edges has no effect.
    @(negedge clk);
    a = 4'b0101;
    @(posedge clk); #1;
    check("pre_glitch", {4'b0, q}, 8'b0101);
    #3 a = 4'b1010;
    #1;
    check("during_glitch", {4'b0, q}, 8'b0101);
    #3 a = 4'b0101;
    @(posedge clk); #1;
    check("after_glitch", {4'b0, q}, 8'b0101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_pipomod
